// File: rtl/matmul_sp_writeback_pkg.sv
// Shared sizing, FSM encoding and slice helpers for the matmul result scratchpad.
// Used by both the calc unit and the writeback/scratchpad block.
package matmul_sp_writeback_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int BUS_WIDTH   = 16;
  localparam int SP_NTARGETS = 4;

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int EW      = 2 * DATA_WIDTH;
  localparam int RW      = MAX_DIM * EW;
  localparam int MW      = MAX_DIM * MAX_DIM * EW;
  localparam int NF      = MAX_DIM * MAX_DIM;
  localparam int TW      = $clog2(SP_NTARGETS);
  localparam int DW      = $clog2(MAX_DIM);
  localparam int AW      = TW + 2 * DW;
  localparam int NROWS   = SP_NTARGETS * MAX_DIM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

  function automatic logic [RW-1:0] get_row(input logic [MW-1:0] m, input logic [DW-1:0] r);
    return m[int'(r) * RW +: RW];
  endfunction

  function automatic logic [EW-1:0] get_elem(input logic [RW-1:0] row, input logic [DW-1:0] c);
    return row[int'(c) * EW +: EW];
  endfunction
endpackage

// File: rtl/matmul_sp_writeback_if.sv
// Signal bundle between the calc unit / bus side and the result scratchpad.
// enable_w_i is a single-cycle pulse with no back-pressure; rd_valid_o marks the cycle rd_data_o is fresh.
interface matmul_sp_writeback_if;
  import matmul_sp_writeback_pkg::*;

  logic            enable_w_i;
  logic [MW-1:0]   c_matrix_i;
  logic [NF-1:0]   flags_i;
  logic [TW-1:0]   wr_target_i;
  logic [TW-1:0]   bias_target_i;
  logic            rd_en_i;
  logic [AW-1:0]   rd_addr_i;
  logic [BUS_WIDTH-1:0] rd_data_o;
  logic            rd_valid_o;
  logic [MW-1:0]   c_bias_o;
  logic [NF-1:0]   flags_o;
  logic            busy_o;
  logic            wr_done_o;
  logic            overrun_o;
  wb_state_e       state_o;

  modport master (
    output enable_w_i, c_matrix_i, flags_i, wr_target_i, bias_target_i, rd_en_i, rd_addr_i,
    input  rd_data_o, rd_valid_o, c_bias_o, flags_o, busy_o, wr_done_o, overrun_o, state_o
  );

  modport slave (
    input  enable_w_i, c_matrix_i, flags_i, wr_target_i, bias_target_i, rd_en_i, rd_addr_i,
    output rd_data_o, rd_valid_o, c_bias_o, flags_o, busy_o, wr_done_o, overrun_o, state_o
  );
endinterface

// File: rtl/matmul_sp_bank.sv
// Flop-based result storage: one row write port, one registered element read port
// and one registered full-slot read port (the C-bias operand).
module matmul_sp_bank
  import matmul_sp_writeback_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_wr_en,
  input  logic [TW+DW-1:0]  i_wr_row,
  input  logic [RW-1:0]     i_wr_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [EW-1:0]     o_rd_data,
  output logic              o_rd_valid,
  input  logic [TW-1:0]     i_slot_sel,
  output logic [MW-1:0]     o_slot_data
);
  logic [RW-1:0] r_mem [NROWS];
  logic [EW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic [MW-1:0] r_slot;
  logic [MW-1:0] w_slot;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NROWS; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_row] <= i_wr_data;
    end
  end

  // Reads sample storage before this edge's row write lands (read-before-write).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) r_rd_data <= get_elem(r_mem[i_rd_addr[AW-1:DW]], i_rd_addr[DW-1:0]);
    end
  end

  always_comb begin
    w_slot = '0;
    for (int r = 0; r < MAX_DIM; r++) w_slot[r*RW +: RW] = r_mem[{i_slot_sel, DW'(r)}];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_slot <= '0;
    else       r_slot <= w_slot;
  end

  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_slot_data = r_slot;
endmodule

// File: rtl/matmul_sp_writeback.sv
// Captures a one-cycle result pulse from the calc unit and streams it row by row
// into a scratchpad slot; serves element reads and the C-bias operand.
module matmul_sp_writeback
  import matmul_sp_writeback_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  matmul_sp_writeback_if.slave bus
);
  wb_state_e     r_state;
  logic [MW-1:0] r_stage_m;
  logic [NF-1:0] r_stage_f;
  logic [TW-1:0] r_stage_t;
  logic [DW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [NF-1:0] r_flags;
  logic          r_overrun;

  logic              w_wr_en;
  logic [TW+DW-1:0]  w_wr_row;
  logic [RW-1:0]     w_wr_data;
  logic [EW-1:0]     w_rd_data;
  logic              w_rd_valid;
  logic [MW-1:0]     w_bias;

  // A pulse arriving outside IDLE is dropped and only recorded in the sticky overrun flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_stage_m <= '0;
      r_stage_f <= '0;
      r_stage_t <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_flags   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.enable_w_i) begin
            r_stage_m <= bus.c_matrix_i;
            r_stage_f <= bus.flags_i;
            r_stage_t <= bus.wr_target_i;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.enable_w_i) r_overrun <= 1'b1;
          r_cnt <= r_cnt + DW'(1);
          if (r_cnt == DW'(MAX_DIM - 1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.enable_w_i) r_overrun <= 1'b1;
          r_done  <= 1'b1;
          r_flags <= r_stage_f;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_wr_en   = (r_state == ST_WRITE);
  assign w_wr_row  = {r_stage_t, r_cnt};
  assign w_wr_data = get_row(r_stage_m, r_cnt);

  matmul_sp_bank u_bank (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_wr_en     (w_wr_en),
    .i_wr_row    (w_wr_row),
    .i_wr_data   (w_wr_data),
    .i_rd_en     (bus.rd_en_i),
    .i_rd_addr   (bus.rd_addr_i),
    .o_rd_data   (w_rd_data),
    .o_rd_valid  (w_rd_valid),
    .i_slot_sel  (bus.bias_target_i),
    .o_slot_data (w_bias)
  );

  assign bus.rd_data_o  = w_rd_data;
  assign bus.rd_valid_o = w_rd_valid;
  assign bus.c_bias_o   = w_bias;
  assign bus.flags_o    = r_flags;
  assign bus.busy_o     = r_busy;
  assign bus.wr_done_o  = r_done;
  assign bus.overrun_o  = r_overrun;
  assign bus.state_o    = r_state;
endmodule

// File: tb/tb_matmul_sp_writeback.sv
// Scoreboarded bench for matmul_sp_writeback: directed scenarios plus random
// writes/reads checked against an element-level scratchpad model.
module tb_matmul_sp_writeback;
  import matmul_sp_writeback_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_sp_writeback_if bus();

  matmul_sp_writeback dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] model_mem [SP_NTARGETS][MAX_DIM][MAX_DIM];
  logic [NF-1:0] exp_flags   = '0;
  logic          exp_overrun = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every valid read response pops one expected element
  always @(negedge clk) begin
    if (bus.rd_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %h with nothing expected", bus.rd_data_o);
      end else begin
        chk("rd_data", MW'(bus.rd_data_o), MW'(exp_q.pop_front()));
      end
    end
  end

  // reference model helpers
  function automatic logic [EW-1:0] elem_of(input logic [MW-1:0] m, input int r, input int c);
    return m[(r*MAX_DIM + c)*EW +: EW];
  endfunction

  function automatic logic [MW-1:0] model_slot(input int s);
    logic [MW-1:0] v;
    v = '0;
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        v[(r*MAX_DIM + c)*EW +: EW] = model_mem[s][r][c];
    return v;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SP_NTARGETS; s++)
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++)
          model_mem[s][r][c] = '0;
  endtask

  task automatic model_store(input logic [MW-1:0] m, input int s);
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        model_mem[s][r][c] = elem_of(m, r, c);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input int s, input int r, input int c);
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = {TW'(s), DW'(r), DW'(c)};
    exp_q.push_back(model_mem[s][r][c]);
    step();
    bus.rd_en_i = 1'b0;
  endtask

  task automatic chk_bias(input int s);
    bus.bias_target_i = TW'(s);
    step();
    chk("c_bias", bus.c_bias_o, model_slot(s));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    MW'(bus.busy_o),     '0);
    chk({tag, "_done"},    MW'(bus.wr_done_o),  '0);
    chk({tag, "_overrun"}, MW'(bus.overrun_o),  '0);
    chk({tag, "_flags"},   MW'(bus.flags_o),    '0);
    chk({tag, "_rdvalid"}, MW'(bus.rd_valid_o), '0);
    chk({tag, "_rddata"},  MW'(bus.rd_data_o),  '0);
    chk({tag, "_bias"},    bus.c_bias_o,        '0);
    chk({tag, "_state"},   MW'(bus.state_o),    MW'(ST_IDLE));
  endtask

  // Full writeback with timing checks. ov: second pulse sampled two edges after
  // acceptance. rdw: read {t,0,1} at the edge writing row 0, then again one edge later.
  task automatic do_write(input logic [MW-1:0] m, input logic [NF-1:0] f, input int t,
                          input bit ov, input bit rdw);
    logic [NF-1:0] prev_flags;
    prev_flags = exp_flags;
    bus.c_matrix_i  = m;
    bus.flags_i     = f;
    bus.wr_target_i = TW'(t);
    bus.enable_w_i  = 1'b1;
    step();
    bus.enable_w_i  = 1'b0;
    bus.c_matrix_i  = ~m;
    bus.flags_i     = ~f;
    bus.wr_target_i = TW'(t ^ 1);
    for (int k = 0; k <= MAX_DIM; k++) begin
      chk("busy_during", MW'(bus.busy_o), MW'(1'b1));
      chk("done_early", MW'(bus.wr_done_o), '0);
      chk("flags_hold", MW'(bus.flags_o), MW'(prev_flags));
      chk("overrun_during", MW'(bus.overrun_o), MW'(exp_overrun | (ov && k >= 2)));
      bus.enable_w_i = (ov && k == 1);
      if (rdw && k == 0) begin
        bus.rd_en_i   = 1'b1;
        bus.rd_addr_i = {TW'(t), DW'(0), DW'(1)};
        exp_q.push_back(model_mem[t][0][1]);
      end else if (rdw && k == 1) begin
        bus.rd_en_i   = 1'b1;
        bus.rd_addr_i = {TW'(t), DW'(0), DW'(1)};
        exp_q.push_back(elem_of(m, 0, 1));
      end else begin
        bus.rd_en_i = 1'b0;
      end
      step();
    end
    bus.enable_w_i = 1'b0;
    bus.rd_en_i    = 1'b0;
    model_store(m, t);
    exp_flags = f;
    if (ov) exp_overrun = 1'b1;
    chk("busy_after", MW'(bus.busy_o), '0);
    chk("wr_done", MW'(bus.wr_done_o), MW'(1'b1));
    chk("flags_new", MW'(bus.flags_o), MW'(exp_flags));
    chk("overrun_after", MW'(bus.overrun_o), MW'(exp_overrun));
    step();
    chk("done_pulse_end", MW'(bus.wr_done_o), '0);
  endtask

  initial begin
    logic [MW-1:0] rm;
    model_clear();
    bus.enable_w_i    = 1'b0;
    bus.c_matrix_i    = '0;
    bus.flags_i       = '0;
    bus.wr_target_i   = '0;
    bus.bias_target_i = '0;
    bus.rd_en_i       = 1'b0;
    bus.rd_addr_i     = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("por");
    rst = 1'b0;
    step();

    // basic write into slot 2 with flags 0101
    do_write(64'h0004_FFFE_0003_0001, 4'b0101, 2, 1'b0, 1'b0);
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = {TW'(2), DW'(0), DW'(0)};
    exp_q.push_back(16'h0001);
    step();
    bus.rd_addr_i = {TW'(2), DW'(1), DW'(1)};
    exp_q.push_back(16'h0004);
    step();
    bus.rd_en_i = 1'b0;
    step();
    step();
    chk("rd_valid_idle", MW'(bus.rd_valid_o), '0);
    chk("rd_data_hold", MW'(bus.rd_data_o), MW'(16'h0004));

    // bias path
    chk_bias(2);
    chk("c_bias_literal", bus.c_bias_o, 64'h0004_FFFE_0003_0001);
    chk_bias(1);

    // overrun: dropped request must not touch either slot
    do_write(64'hAAAA_5555_1234_8765, 4'b1010, 2, 1'b1, 1'b0);
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++) begin
        issue_read(2, r, c);
        issue_read(3, r, c);
      end
    step();
    chk("overrun_sticky", MW'(bus.overrun_o), MW'(1'b1));

    // read during write of the same row
    do_write({$urandom, $urandom}, NF'($urandom_range(0, 15)), 2, 1'b0, 1'b1);
    issue_read(2, 0, 1);

    // random traffic
    repeat (16) begin
      int t;
      t = $urandom_range(0, SP_NTARGETS - 1);
      rm = {$urandom, $urandom};
      do_write(rm, NF'($urandom_range(0, 15)), t, 1'b0, 1'b0);
      repeat (3) issue_read($urandom_range(0, SP_NTARGETS - 1),
                            $urandom_range(0, MAX_DIM - 1), $urandom_range(0, MAX_DIM - 1));
      chk_bias($urandom_range(0, SP_NTARGETS - 1));
    end

    // asynchronous reset in the middle of a writeback
    do_write(64'h1111_2222_3333_4444, 4'hF, 0, 1'b0, 1'b0);
    issue_read(0, 0, 0);
    bus.c_matrix_i  = {$urandom, $urandom};
    bus.wr_target_i = TW'(0);
    bus.enable_w_i  = 1'b1;
    step();
    bus.enable_w_i  = 1'b1;
    step();
    bus.enable_w_i  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    model_clear();
    exp_flags   = '0;
    exp_overrun = 1'b0;
    step();
    rst = 1'b0;
    step();
    issue_read(0, 0, 0);
    issue_read(2, 1, 1);
    chk_bias(2);
    chk_bias(0);

    repeat (3) step();
    chk("queue_drained", MW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
